// File: rtl/uart_rx.sv
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART receiver with 2-flop input synchroniser, mid-bit
//             majority-of-3 sampling, and one-cycle valid/frame-error strobes.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int c_MID = CLKS_PER_BIT / 2;
    localparam int c_CW  = $clog2(CLKS_PER_BIT);

    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_SMP0     = c_CW'(c_MID - 1);
    localparam logic [c_CW-1:0] c_SMP1     = c_CW'(c_MID);
    localparam logic [c_CW-1:0] c_DECIDE   = c_CW'(c_MID + 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_START = 2'd1;
    localparam logic [1:0] c_S_DATA  = 2'd2;
    localparam logic [1:0] c_S_STOP  = 2'd3;

    logic            r_sync1;
    logic            r_sync2;
    logic            r_prev;
    logic [1:0]      r_fill;
    logic            r_armed;
    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [3:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_smp0;
    logic            r_smp1;

    logic            w_rx_s;
    logic            w_fall;
    logic            w_maj;
    logic            w_wrap;
    logic            w_decide;

    assign w_rx_s   = r_sync2;
    assign w_fall   = r_armed & r_prev & ~w_rx_s;
    assign w_maj    = (r_smp0 & r_smp1) | (r_smp0 & w_rx_s) | (r_smp1 & w_rx_s);
    assign w_wrap   = (r_cnt == c_CNT_LAST);
    assign w_decide = (r_cnt == c_DECIDE);
    assign busy     = (r_state != c_S_IDLE);

    // The synchroniser flops come out of reset high, so a line held low
    // through reset would otherwise look like a fresh start bit once real
    // samples reach rx_s. r_fill marks when rx_s carries a genuine sample;
    // start detection stays disarmed until such a sample has been seen high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_fill  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_prev  <= w_rx_s;
            r_fill  <= {r_fill[0], 1'b1};
            if (r_fill[1] && w_rx_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 4'd0;
            r_shift   <= 8'h00;
            r_smp0    <= 1'b1;
            r_smp1    <= 1'b1;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            r_cnt     <= w_wrap ? '0 : r_cnt + 1'b1;

            if (r_cnt == c_SMP0) begin
                r_smp0 <= w_rx_s;
            end
            if (r_cnt == c_SMP1) begin
                r_smp1 <= w_rx_s;
            end

            case (r_state)
                c_S_IDLE: begin
                    r_cnt <= '0;
                    if (w_fall) begin
                        r_state <= c_S_START;
                    end
                end

                c_S_START: begin
                    // A start bit that reads high at its centre was a glitch.
                    if (w_decide && w_maj) begin
                        r_state <= c_S_IDLE;
                        r_cnt   <= '0;
                    end else if (w_wrap) begin
                        r_state   <= c_S_DATA;
                        r_bit_idx <= 4'd0;
                    end
                end

                c_S_DATA: begin
                    if (w_decide) begin
                        r_shift   <= {w_maj, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 4'd1;
                    end
                    if (w_wrap && (r_bit_idx == 4'd8)) begin
                        r_state <= c_S_STOP;
                    end
                end

                c_S_STOP: begin
                    // Leave at mid-stop so an immediately following start bit is caught.
                    if (w_decide) begin
                        if (w_maj) begin
                            rx_data  <= r_shift;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        r_state <= c_S_IDLE;
                        r_cnt   <= '0;
                    end
                end

                default: begin
                    r_state <= c_S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Scoreboard bench for uart_rx at 16 clocks per bit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

    localparam int c_CPB = 16;
    // Edge is detected two clocks after rx is driven low, then 1+9*16+8+2.
    localparam int c_LAT = 2 + 1 + 9 * c_CPB + (c_CPB / 2) + 2;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    ev_t        sb[$];
    int         n_vec;
    int         n_err;
    int         cyc;
    int         t0;
    bit         lat_arm;
    logic [7:0] last_good;

    uart_rx #(.CLKS_PER_BIT(c_CPB)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        @(posedge clk);
        #1 rx = b;
        repeat (c_CPB - 1) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_val, input int nstop);
        @(posedge clk);
        #1 rx = 1'b0;
        t0 = cyc;
        repeat (c_CPB - 1) @(posedge clk);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        for (int i = 0; i < nstop; i++) drive_bit(stop_val);
    endtask

    task automatic push_good(input logic [7:0] d);
        sb.push_back('{err: 1'b0, data: d});
        last_good = d;
    endtask

    // Output monitor: every strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && (rx_valid || frame_err)) begin
            ev_t e;
            check("strobe_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
            check("sb_pending", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("strobe_kind", {31'd0, frame_err}, {31'd0, e.err});
                check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                if (rx_valid) check("busy_after_valid", {31'd0, busy}, 32'd0);
            end
            if (lat_arm) begin
                check("latency", cyc - t0, c_LAT);
                lat_arm = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        lat_arm   = 1'b0;
        last_good = 8'h00;
        t0        = 0;
        rst_n     = 1'b0;
        rx        = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset_rx_data", {24'd0, rx_data}, 32'h00);
        check("reset_flags", {29'd0, rx_valid, frame_err, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);

        // Bad stop bit held low two bit times, then line high, then good frame.
        sb.push_back('{err: 1'b1, data: last_good});
        send_frame(8'h5A, 1'b0, 2);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        push_good(8'h81);
        send_frame(8'h81, 1'b1, 1);
        for (int i = 0; i < 2; i++) drive_bit(1'b1);

        // Single frame with latency measurement.
        push_good(8'hA5);
        lat_arm = 1'b1;
        send_frame(8'hA5, 1'b1, 1);
        for (int i = 0; i < 2; i++) drive_bit(1'b1);
        check("latency_seen", {31'd0, lat_arm}, 32'd0);

        // Back-to-back frames.
        push_good(8'h00);
        send_frame(8'h00, 1'b1, 1);
        push_good(8'hFF);
        send_frame(8'hFF, 1'b1, 1);
        for (int i = 0; i < 2; i++) drive_bit(1'b1);

        // Three-cycle glitch on an idle line.
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_high", {31'd0, busy}, 32'd1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_low", {31'd0, busy}, 32'd0);
        drive_bit(1'b1);
        push_good(8'h3C);
        send_frame(8'h3C, 1'b1, 1);
        for (int i = 0; i < 2; i++) drive_bit(1'b1);

        // Reset asserted during bit 4 of 8'hC3 while the line is low.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(((8'hC3 >> i) & 8'h01) != 0);
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_rx_data", {24'd0, rx_data}, 32'h00);
        check("midreset_flags", {29'd0, rx_valid, frame_err, busy}, 32'd0);
        last_good = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        for (int i = 5; i < 8; i++) drive_bit(((8'hC3 >> i) & 8'h01) != 0);
        drive_bit(1'b1);
        for (int i = 0; i < 2; i++) drive_bit(1'b1);
        check("after_reset_frame_data", {24'd0, rx_data}, 32'h00);
        push_good(8'h11);
        send_frame(8'h11, 1'b1, 1);

        for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        check("sb_drained", sb.size(), 32'd0);
        check("final_rx_data", {24'd0, rx_data}, 32'h11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
